pipelined_adder: RTL and testbench

//  - Parametrised, pipelined multi-bit adder built from per-segment ripple-carry slices.
//  - Splits WIDTH-bit operands into SEGMENTS slices; one slice is added per clock stage.
//  - Carry moves stage to stage; operand slices are skewed so one add enters per cycle.
//  - Sits between operand producers and consumers on a valid/ready stream.

---
 rtl/pipelined_adder.sv | 158 +++++++++++++++
 tb/tb_pipelined_adder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder split into SEGMENTS ripple-carry slices,
// one slice per pipeline stage, with a valid/ready stream on both sides.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operands a/b/cin valid this cycle
//   in_ready   block accepts operands this cycle (combinational from out_ready)
//   a, b       WIDTH-bit operands
//   cin        carry into bit 0
//   out_valid  sum/cout valid
//   out_ready  consumer accepts result
//   sum        a + b + cin modulo 2^WIDTH
//   cout       carry out of bit WIDTH-1
//   ovf        signed overflow, aligned with sum (only with PIPELINED_ADDER_OVERFLOW_EN)
//
// Optional feature macro: PIPELINED_ADDER_OVERFLOW_EN adds the ovf output.
//
// Stage k holds valid, the low (k+1) sum slices, the carry out of slice k, and
// the operand slices still waiting to be added. The whole chain advances
// together whenever the output is not stalled.

module pipelined_adder #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned SEGMENTS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPELINED_ADDER_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned SEG_W = WIDTH / SEGMENTS;

  // Elaboration-time parameter checks
  if (WIDTH < 2) begin : g_chk_width
    $error("pipelined_adder: WIDTH must be >= 2");
  end
  if ((SEGMENTS == 0) || (WIDTH % SEGMENTS != 0)) begin : g_chk_seg
    $error("pipelined_adder: WIDTH must be a non-zero multiple of SEGMENTS");
  end

  // Output stall freezes every stage at once
  logic stall_c;
  assign stall_c  = out_valid & ~out_ready;
  assign in_ready = ~stall_c;

  for (genvar k = 0; k < SEGMENTS; k++) begin : g_stg
    localparam int unsigned DONE_W = (k + 1) * SEG_W;

    logic              vld_q;
    logic              cy_q;
    logic [DONE_W-1:0] sum_q;

    logic              vld_d;
    logic              cy_in;
    logic [SEG_W-1:0]  a_s;
    logic [SEG_W-1:0]  b_s;
    logic [SEG_W:0]    slice_c;
    logic [DONE_W-1:0] sum_d;

    // Stage 0 takes the live operands; later stages take the skewed slices
    if (k == 0) begin : g_head
      assign vld_d = in_valid;
      assign cy_in = cin;
      assign a_s   = a[SEG_W-1:0];
      assign b_s   = b[SEG_W-1:0];
      assign sum_d = slice_c[SEG_W-1:0];
    end else begin : g_body
      assign vld_d = g_stg[k-1].vld_q;
      assign cy_in = g_stg[k-1].cy_q;
      assign a_s   = g_stg[k-1].g_rem.a_rem_q[SEG_W-1:0];
      assign b_s   = g_stg[k-1].g_rem.b_rem_q[SEG_W-1:0];
      assign sum_d = {slice_c[SEG_W-1:0], g_stg[k-1].sum_q};
    end

    // Ripple-carry slice add
    assign slice_c = {1'b0, a_s} + {1'b0, b_s} + (SEG_W+1)'(cy_in);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        sum_q <= '0;
      end else if (!stall_c) begin
        vld_q <= vld_d;
        cy_q  <= slice_c[SEG_W];
        sum_q <= sum_d;
      end
    end

    // Operand slices not yet consumed travel alongside the add
    if (k < SEGMENTS - 1) begin : g_rem
      localparam int unsigned REM_W = WIDTH - DONE_W;

      logic [REM_W-1:0] a_rem_q;
      logic [REM_W-1:0] b_rem_q;
      logic [REM_W-1:0] a_rem_d;
      logic [REM_W-1:0] b_rem_d;

      if (k == 0) begin : g_src_in
        assign a_rem_d = a[WIDTH-1:SEG_W];
        assign b_rem_d = b[WIDTH-1:SEG_W];
      end else begin : g_src_stg
        assign a_rem_d = g_stg[k-1].g_rem.a_rem_q[REM_W+SEG_W-1:SEG_W];
        assign b_rem_d = g_stg[k-1].g_rem.b_rem_q[REM_W+SEG_W-1:SEG_W];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_rem_q <= '0;
          b_rem_q <= '0;
        end else if (!stall_c) begin
          a_rem_q <= a_rem_d;
          b_rem_q <= b_rem_d;
        end
      end
    end

`ifdef PIPELINED_ADDER_OVERFLOW_EN
    if (k == SEGMENTS - 1) begin : g_ovf
      logic ovf_q;
      logic msb_cin;

      // Carry into the MSB recovered from the MSB's own sum bit
      assign msb_cin = a_s[SEG_W-1] ^ b_s[SEG_W-1] ^ slice_c[SEG_W-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (!stall_c) begin
          ovf_q <= msb_cin ^ slice_c[SEG_W];
        end
      end
    end
`endif
  end

  assign out_valid = g_stg[SEGMENTS-1].vld_q;
  assign sum       = g_stg[SEGMENTS-1].sum_q;
  assign cout      = g_stg[SEGMENTS-1].cy_q;

`ifdef PIPELINED_ADDER_OVERFLOW_EN
  assign ovf = g_stg[SEGMENTS-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed table of single adds, streaming,
// backpressure, reset mid-flight, random stream against a queue model, and
// latency/arithmetic sweeps on WIDTH=8/SEGMENTS=1 and WIDTH=32/SEGMENTS=8.

module tb_pipelined_adder;

  localparam int unsigned W = 16;
  localparam int unsigned S = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance
  logic         in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;

  pipelined_adder #(.WIDTH(W), .SEGMENTS(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    , .ovf(ovf)
`endif
  );
`ifndef PIPELINED_ADDER_OVERFLOW_EN
  assign ovf = 1'b0;
`endif

  // Sweep instances
  logic       s8_iv, s8_ir, s8_ci, s8_ov, s8_or, s8_co, s8_of;
  logic [7:0] s8_a, s8_b, s8_s;
  logic        s32_iv, s32_ir, s32_ci, s32_ov, s32_or, s32_co, s32_of;
  logic [31:0] s32_a, s32_b, s32_s;

  pipelined_adder #(.WIDTH(8), .SEGMENTS(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(s8_iv), .in_ready(s8_ir),
    .a(s8_a), .b(s8_b), .cin(s8_ci), .out_valid(s8_ov), .out_ready(s8_or),
    .sum(s8_s), .cout(s8_co)
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    , .ovf(s8_of)
`endif
  );

  pipelined_adder #(.WIDTH(32), .SEGMENTS(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(s32_iv), .in_ready(s32_ir),
    .a(s32_a), .b(s32_b), .cin(s32_ci), .out_valid(s32_ov), .out_ready(s32_or),
    .sum(s32_s), .cout(s32_co)
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    , .ovf(s32_of)
`endif
  );
`ifndef PIPELINED_ADDER_OVERFLOW_EN
  assign s8_of  = 1'b0;
  assign s32_of = 1'b0;
`endif

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ov;
  } res_t;

  typedef struct {
    logic        v;
    logic [31:0] s;
    logic        co;
    logic        ov;
  } tok_t;

  res_t sb[$];
  tok_t q8[$];
  tok_t q32[$];
  vec_t tbl[8];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: full-precision integer arithmetic
  function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic c);
    res_t        r;
    logic [16:0] full;
    int          sx;
    full = 17'(x) + 17'(y) + 17'(c);
    r.s  = full[15:0];
    r.co = full[16];
    sx   = int'($signed(x)) + int'($signed(y)) + int'(c);
    r.ov = (sx > 32767) || (sx < -32768);
    return r;
  endfunction

  // Single isolated add: checks latency, then result
  task automatic run_single(input string nm, input vec_t v);
    a = v.a; b = v.b; cin = v.ci; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i < int'(S); i++) begin
      chk({nm, "_early"}, 64'(out_valid), 64'(1'b0));
      @(posedge clk); #1;
    end
    chk({nm, "_valid"}, 64'(out_valid), 64'(1'b1));
    chk({nm, "_sum"}, 64'(sum), 64'(v.s));
    chk({nm, "_cout"}, 64'(cout), 64'(v.co));
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    chk({nm, "_ovf"}, 64'(ovf), 64'(v.ov));
`endif
    @(posedge clk); #1;
  endtask

  // One stream cycle with scoreboard, ready and hold checks
  task automatic cycle(input logic iv, input logic [15:0] x, input logic [15:0] y,
                       input logic c, input logic ordy);
    logic        stall_now, hv, hc, ho;
    logic [15:0] hs;
    res_t        e;
    in_valid = iv; a = x; b = y; cin = c; out_ready = ordy;
    #1;
    stall_now = out_valid && !ordy;
    chk("in_ready", 64'(in_ready), 64'(!stall_now));
    if (out_valid && ordy) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL stream_extra: got result 0x%0h with nothing outstanding", sum);
      end else begin
        e = sb.pop_front();
        chk("stream_sum", 64'(sum), 64'(e.s));
        chk("stream_cout", 64'(cout), 64'(e.co));
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        chk("stream_ovf", 64'(ovf), 64'(e.ov));
`endif
      end
    end
    if (iv && in_ready) sb.push_back(model(x, y, c));
    hv = out_valid; hs = sum; hc = cout; ho = ovf;
    @(posedge clk); #1;
    if (stall_now) begin
      chk("hold_valid", 64'(out_valid), 64'(hv));
      chk("hold_sum", 64'(sum), 64'(hs));
      chk("hold_cout", 64'(cout), 64'(hc));
      chk("hold_ovf", 64'(ovf), 64'(ho));
    end
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 40 && sb.size() != 0; i++) cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk({nm, "_all_delivered"}, 64'(sb.size()), 64'(0));
    chk({nm, "_idle"}, 64'(out_valid), 64'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    tbl[2] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[5] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[6] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    tbl[7] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    s8_iv = 1'b0; s8_a = '0; s8_b = '0; s8_ci = 1'b0; s8_or = 1'b1;
    s32_iv = 1'b0; s32_a = '0; s32_b = '0; s32_ci = 1'b0; s32_or = 1'b1;

    // Reset state
    @(posedge clk); #1;
    chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
    chk("rst_sum", 64'(sum), 64'(16'h0));
    chk("rst_cout", 64'(cout), 64'(1'b0));
    chk("rst_ovf", 64'(ovf), 64'(1'b0));
    chk("rst_in_ready", 64'(in_ready), 64'(1'b1));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table of isolated adds
    for (int i = 0; i < 8; i++) run_single($sformatf("vec%0d", i), tbl[i]);

    // Streaming: three back-to-back accepts, results on consecutive cycles
    cycle(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b1);
    cycle(1'b1, 16'h0002, 16'h0002, 1'b0, 1'b1);
    cycle(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b1);
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("stream_v0", 64'(out_valid), 64'(1'b1));
    chk("stream_first_sum", 64'(sum), 64'(16'h0002));
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("stream_v1", 64'(out_valid), 64'(1'b1));
    chk("stream_second_sum", 64'(sum), 64'(16'h0004));
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("stream_v2", 64'(out_valid), 64'(1'b1));
    chk("stream_third_cout", 64'(cout), 64'(1'b1));
    cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("stream_v3", 64'(out_valid), 64'(1'b0));
    drain("stream");

    // Backpressure: out_ready low for 3 cycles with a result waiting
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'(16'h1111 * (i + 1)), 16'h0F0F, 1'(i), 1'b1);
    chk("bp_out_valid", 64'(out_valid), 64'(1'b1));
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'hDEAD, 16'hBEEF, 1'b1, 1'b0);
    drain("bp");

    // Random stream with random bubbles and backpressure
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 1'($urandom),
            $urandom_range(0, 3) != 0);
    drain("rand");

    // Reset with adds in flight
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'(i + 3), 16'h0100, 1'b0, 1'b1);
    chk("prerst_out_valid", 64'(out_valid), 64'(1'b1));
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(1'b0));
    chk("midrst_sum", 64'(sum), 64'(16'h0));
    chk("midrst_cout", 64'(cout), 64'(1'b0));
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("postrst_quiet", 64'(out_valid), 64'(1'b0));
    end
    run_single("postrst", tbl[1]);

    // Parameter sweep: random tokens on both instances, delay-line model
    for (int i = 0; i < 200; i++) begin
      tok_t        t8, t32;
      logic [8:0]  f8;
      logic [32:0] f32;
      s8_iv = ($urandom_range(0, 4) != 0);
      s8_a = 8'($urandom); s8_b = 8'($urandom); s8_ci = 1'($urandom);
      s32_iv = ($urandom_range(0, 4) != 0);
      s32_a = $urandom; s32_b = $urandom; s32_ci = 1'($urandom);
      f8  = 9'(s8_a) + 9'(s8_b) + 9'(s8_ci);
      f32 = 33'(s32_a) + 33'(s32_b) + 33'(s32_ci);
      t8  = '{s8_iv, 32'(f8[7:0]), f8[8],
              (s8_a[7] == s8_b[7]) && (f8[7] != s8_a[7])};
      t32 = '{s32_iv, f32[31:0], f32[32],
              (s32_a[31] == s32_b[31]) && (f32[31] != s32_a[31])};
      q8.push_back(t8);
      q32.push_back(t32);
      @(posedge clk); #1;
      if (q8.size() == 1) begin
        t8 = q8.pop_front();
        chk("w8_valid", 64'(s8_ov), 64'(t8.v));
        if (t8.v) begin
          chk("w8_sum", 64'(s8_s), 64'(t8.s[7:0]));
          chk("w8_cout", 64'(s8_co), 64'(t8.co));
`ifdef PIPELINED_ADDER_OVERFLOW_EN
          chk("w8_ovf", 64'(s8_of), 64'(t8.ov));
`endif
        end
      end
      if (q32.size() == 8) begin
        t32 = q32.pop_front();
        chk("w32_valid", 64'(s32_ov), 64'(t32.v));
        if (t32.v) begin
          chk("w32_sum", 64'(s32_s), 64'(t32.s));
          chk("w32_cout", 64'(s32_co), 64'(t32.co));
`ifdef PIPELINED_ADDER_OVERFLOW_EN
          chk("w32_ovf", 64'(s32_of), 64'(t32.ov));
`endif
        end
      end
    end
    chk("w8_in_ready", 64'(s8_ir), 64'(1'b1));
    chk("w32_in_ready", 64'(s32_ir), 64'(1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
